ika87ad_extbus_resp: RTL

IKA87AD_EXTBUS_RESP -- requirements
Module: ika87ad_extbus_resp

---
 rtl/ika87ad_pkg.sv | 13 +
 rtl/ika87ad_strobe_edge.sv | 21 ++
 rtl/ika87ad_extbus_resp.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/ika87ad_pkg.sv
// Shared types and constants for the IKA87AD external-bus responder.
package ika87ad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RD_HOLD,
    WR_WAIT
  } state_t;

  localparam logic [7:0] OPEN_BUS_DEFAULT = 8'hFF;

endpackage

// File: rtl/ika87ad_strobe_edge.sv
// Registers one active-low CPU strobe and flags its falling or rising edge.
module ika87ad_strobe_edge #(
  parameter bit FALLING = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe,
  output logic hit
);

  logic q;

  // Resetting high means a strobe that is idle at reset release produces no edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b1;
    else        q <= strobe;
  end

  assign hit = FALLING ? (q & ~strobe) : (~q & strobe);

endmodule

// File: rtl/ika87ad_extbus_resp.sv
// Turns IKA87AD read/write strobes into level request/ACK transactions on a
// backing store, with timeout, one deferred read and sticky status flags.
module ika87ad_extbus_resp
  import ika87ad_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 15,
  parameter logic [7:0]  OPEN_BUS = OPEN_BUS_DEFAULT
) (
  input  logic        i_EMUCLK,
  input  logic        i_RESET_n,
  input  logic [15:0] i_A,
  input  logic        i_RD_n,
  input  logic        i_WR_n,
  input  logic [7:0]  i_DO,
  output logic [7:0]  o_DI,
  output logic        o_MEM_REQ,
  output logic        o_MEM_WE,
  output logic [15:0] o_MEM_ADDR,
  output logic [7:0]  o_MEM_WDATA,
  input  logic        i_MEM_ACK,
  input  logic [7:0]  i_MEM_RDATA,
  input  logic        i_STAT_CLR,
  output logic        o_TMO,
  output logic        o_OVF
);

  localparam int unsigned   CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  state_t        state;
  logic          rd_fall;
  logic          wr_rise;
  logic          rd_start;
  logic          wr_end;
  logic          timed_out;
  logic          read_pend;
  logic          set_tmo;
  logic          set_ovf;
  logic [CW-1:0] wait_cnt;
  logic [15:0]   pay_addr;
  logic [7:0]    pay_data;
  logic [15:0]   def_addr;
  logic          def_pend;

  ika87ad_strobe_edge #(.FALLING(1'b1)) u_rd_edge (
    .clk    (i_EMUCLK),
    .rst_n  (i_RESET_n),
    .strobe (i_RD_n),
    .hit    (rd_fall)
  );

  ika87ad_strobe_edge #(.FALLING(1'b0)) u_wr_edge (
    .clk    (i_EMUCLK),
    .rst_n  (i_RESET_n),
    .strobe (i_WR_n),
    .hit    (wr_rise)
  );

  assign rd_start  = rd_fall & i_WR_n;
  assign wr_end    = wr_rise;
  assign timed_out = (wait_cnt == LAST);
  assign read_pend = def_pend | rd_start;
  assign set_ovf   = wr_end & (state != IDLE);
  assign set_tmo   = o_MEM_REQ & ~i_MEM_ACK & timed_out &
                     ((state == RD_WAIT) | (state == WR_WAIT));

  always_ff @(posedge i_EMUCLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      pay_addr <= '0;
      pay_data <= '0;
    end else if (!i_WR_n) begin
      pay_addr <= i_A;
      pay_data <= i_DO;
    end
  end

  always_ff @(posedge i_EMUCLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      o_TMO <= 1'b0;
      o_OVF <= 1'b0;
    end else begin
      if (set_tmo)         o_TMO <= 1'b1;
      else if (i_STAT_CLR) o_TMO <= 1'b0;
      if (set_ovf)         o_OVF <= 1'b1;
      else if (i_STAT_CLR) o_OVF <= 1'b0;
    end
  end

  always_ff @(posedge i_EMUCLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      def_pend    <= 1'b0;
      def_addr    <= '0;
      o_MEM_REQ   <= 1'b0;
      o_MEM_WE    <= 1'b0;
      o_MEM_ADDR  <= '0;
      o_MEM_WDATA <= '0;
      o_DI        <= OPEN_BUS;
    end else begin
      unique case (state)
        IDLE: begin
          if (wr_end) begin
            o_MEM_REQ   <= 1'b1;
            o_MEM_WE    <= 1'b1;
            o_MEM_ADDR  <= pay_addr;
            o_MEM_WDATA <= pay_data;
            wait_cnt    <= '0;
            state       <= WR_WAIT;
            if (rd_start) begin
              def_pend <= 1'b1;
              def_addr <= i_A;
            end
          end else if (rd_start) begin
            o_MEM_REQ  <= 1'b1;
            o_MEM_WE   <= 1'b0;
            o_MEM_ADDR <= i_A;
            wait_cnt   <= '0;
            state      <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          // Entered with REQ low only from WR_WAIT: launch the deferred read first.
          if (!o_MEM_REQ) begin
            o_MEM_REQ  <= 1'b1;
            o_MEM_WE   <= 1'b0;
            o_MEM_ADDR <= def_addr;
            def_pend   <= 1'b0;
            wait_cnt   <= '0;
          end else if (i_MEM_ACK) begin
            o_MEM_REQ <= 1'b0;
            o_DI      <= i_MEM_RDATA;
            state     <= i_RD_n ? IDLE : RD_HOLD;
          end else if (timed_out) begin
            o_MEM_REQ <= 1'b0;
            o_DI      <= OPEN_BUS;
            state     <= RD_HOLD;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RD_HOLD: begin
          if (i_RD_n) state <= IDLE;
        end
        WR_WAIT: begin
          if (rd_start) begin
            def_pend <= 1'b1;
            def_addr <= i_A;
          end
          if (i_MEM_ACK || timed_out) begin
            o_MEM_REQ <= 1'b0;
            wait_cnt  <= '0;
            state     <= read_pend ? RD_WAIT : IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
